imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder_pkg.sv | 21 ++
 rtl/imem_responder_array.sv | 53 +++++
 rtl/imem_responder.sv | 136 +++++++++++++
 tb/tb_imem_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: fault codes and
// the NOP instruction returned in place of a faulting fetch.
package imem_responder_pkg;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_RANGE    = 2'd2,
        FAULT_PARITY   = 2'd3
    } imem_fault_t;

    // RV32I canonical NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_responder_array.sv
// Instruction storage: one write port, one synchronous read port.
// With IMEM_PARITY_EN defined, an even-parity bit is kept alongside each word
// and returned with the read data.
module imem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
`ifdef IMEM_PARITY_EN
    output logic          rpar,
`endif
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Write port and registered read port; the read samples the old word on a
    // same-address write because both use non-blocking updates.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

`ifdef IMEM_PARITY_EN
    logic par_q [DEPTH_WORDS];
    logic rpar_q;

    // Parity bits follow the same write/read timing as the data words.
    always_ff @(posedge CLK) begin
        if (we) begin
            par_q[waddr] <= ^wdata;
        end
        if (re) begin
            rpar_q <= par_q[raddr];
        end
    end

    assign rpar = rpar_q;
`endif

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, returns the
// stored word (or NOP plus a fault code) LATENCY cycles after acceptance and
// holds it until the consumer takes it. Words are loaded via the prog_* port.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, FAULT_PARITY).
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [31:0]                    resp_inst,
    output imem_fault_t                    resp_fault,
    input  logic                           prog_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] prog_waddr,
    input  logic [31:0]                    prog_wdata
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    imem_state_t state_q;
    logic [3:0]  cnt_q;
    logic        resp_valid_q;
    logic [31:0] resp_inst_q;
    imem_fault_t resp_fault_q;
    imem_fault_t acc_fault_q;

    logic        accept;
    imem_fault_t req_fault;
    logic [31:0] rdata;
    logic [31:0] inst_d;
    imem_fault_t fault_d;

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;

    // Address checks at acceptance; misalignment wins over the range check.
    always_comb begin
        req_fault = FAULT_NONE;
        if (req_addr[1:0] != 2'b00) begin
            req_fault = FAULT_MISALIGN;
        end else if ((req_addr >> (AW + 2)) != 32'd0) begin
            req_fault = FAULT_RANGE;
        end
    end

`ifdef IMEM_PARITY_EN
    logic rpar;
`endif

    imem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .CLK  (CLK),
        .we   (prog_we && !RST),
        .waddr(prog_waddr),
        .wdata(prog_wdata),
        .re   (accept),
        .raddr(req_addr[AW+1:2]),
`ifdef IMEM_PARITY_EN
        .rpar (rpar),
`endif
        .rdata(rdata)
    );

    // Final response word and fault: any fault substitutes the NOP.
    always_comb begin
        fault_d = acc_fault_q;
        inst_d  = NOP_INST;
        if (acc_fault_q == FAULT_NONE) begin
`ifdef IMEM_PARITY_EN
            if ((^rdata) != rpar) begin
                fault_d = FAULT_PARITY;
            end else begin
                inst_d = rdata;
            end
`else
            inst_d = rdata;
`endif
        end
    end

    // Request/response FSM with latency counter and registered response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= 32'd0;
            resp_fault_q <= FAULT_NONE;
            acc_fault_q  <= FAULT_NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        state_q     <= S_WAIT;
                        cnt_q       <= LAT_M1;
                        acc_fault_q <= req_fault;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_inst_q  <= inst_d;
                        resp_fault_q <= fault_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_inst  = resp_inst_q;
    assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed testbench for imem_responder (DEPTH_WORDS=1024, LATENCY=2).
module tb_imem_responder;
    import imem_responder_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_inst;
    imem_fault_t resp_fault;
    logic        prog_we = 1'b0;
    logic [9:0]  prog_waddr = 10'd0;
    logic [31:0] prog_wdata = 32'd0;

    int errors = 0;
    int checks = 0;

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_inst (resp_inst),
        .resp_fault(resp_fault),
        .prog_we   (prog_we),
        .prog_waddr(prog_waddr),
        .prog_wdata(prog_wdata)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_waddr = a; prog_wdata = d;
        tick();
        prog_we = 1'b0;
    endtask

    // Waits for resp_valid after the acceptance edge; checks latency, data,
    // fault, stability under 'hold' cycles of backpressure, and return to IDLE.
    task automatic wait_resp(input string nm, input logic [31:0] exp_inst,
                             input imem_fault_t exp_fault, input int hold);
        int n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles expected %0d", nm, n, LAT);
        end
        checks++;
        if (resp_inst !== exp_inst) begin
            errors++;
            $display("FAIL %s inst: got %h expected %h", nm, resp_inst, exp_inst);
        end
        checks++;
        if (resp_fault !== exp_fault) begin
            errors++;
            $display("FAIL %s fault: got %0d expected %0d", nm, resp_fault, exp_fault);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b1 || resp_inst !== exp_inst ||
                resp_fault !== exp_fault || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: got v=%b inst=%h f=%0d rdy=%b expected v=1 inst=%h f=%0d rdy=0",
                         nm, i, resp_valid, resp_inst, resp_fault, req_ready, exp_inst, exp_fault);
            end
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got v=%b rdy=%b expected v=0 rdy=1", nm, resp_valid, req_ready);
        end
    endtask

    task automatic fetch(input string nm, input logic [31:0] addr,
                         input logic [31:0] exp_inst, input imem_fault_t exp_fault,
                         input int hold);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: got %b expected 1", nm, req_ready);
        end
        req_valid = 1'b1; req_addr = addr;
        tick();
        req_valid = 1'b0;
        wait_resp(nm, exp_inst, exp_fault, hold);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_inst !== 32'd0 ||
            resp_fault !== FAULT_NONE) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b v=%b inst=%h f=%0d expected rdy=1 v=0 inst=0 f=0",
                     req_ready, resp_valid, resp_inst, resp_fault);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_basic_fetch();
        load(10'd3, 32'hDEADBEEF);
        load(10'd1023, 32'hCAFEF00D);
        fetch("basic", 32'h0000_000C, 32'hDEADBEEF, FAULT_NONE, 0);
        fetch("last_word", 32'h0000_0FFC, 32'hCAFEF00D, FAULT_NONE, 0);
    endtask

    task automatic test_backpressure();
        fetch("backpressure", 32'h0000_000C, 32'hDEADBEEF, FAULT_NONE, 5);
    endtask

    task automatic test_faults();
        fetch("misalign", 32'h0000_0006, NOP_INST, FAULT_MISALIGN, 0);
        fetch("range", 32'h0000_1000, NOP_INST, FAULT_RANGE, 0);
        fetch("misalign_prio", 32'h0000_1002, NOP_INST, FAULT_MISALIGN, 0);
    endtask

    task automatic test_collision();
        load(10'd5, 32'h0000_0002);
        req_valid = 1'b1; req_addr = 32'h0000_0014;
        prog_we = 1'b1; prog_waddr = 10'd5; prog_wdata = 32'h0000_0001;
        tick();
        req_valid = 1'b0; prog_we = 1'b0;
        wait_resp("collision_old", 32'h0000_0002, FAULT_NONE, 0);
        fetch("collision_new", 32'h0000_0014, 32'h0000_0001, FAULT_NONE, 0);
    endtask

    task automatic test_back_to_back();
        load(10'd7, 32'hA5A5_0007);
        fetch("b2b_a", 32'h0000_001C, 32'hA5A5_0007, FAULT_NONE, 0);
        fetch("b2b_b", 32'h0000_0014, 32'h0000_0001, FAULT_NONE, 0);
    endtask

    task automatic test_reset_mid_wait();
        int seen = 0;
        req_valid = 1'b1; req_addr = 32'h0000_000C;
        tick();
        req_valid = 1'b0;
        RST = 1'b1;
        prog_we = 1'b1; prog_waddr = 10'd3; prog_wdata = 32'h1234_5678;
        tick();
        RST = 1'b0; prog_we = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_ready: got %b expected 1", req_ready);
        end
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_wait_noresp: got %0d valid cycles expected 0", seen);
        end
        fetch("rst_keeps_mem", 32'h0000_000C, 32'hDEADBEEF, FAULT_NONE, 0);
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        load(10'd0, 32'h0000_00FF);
        dut.u_array.mem_q[0] = dut.u_array.mem_q[0] ^ 32'h0000_0100;
        fetch("parity", 32'h0000_0000, NOP_INST, FAULT_PARITY, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_faults();
        test_collision();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
